// File: rtl/laser_tx_scheduler.sv
// Dual-lane laser transmit scheduler: gathers host bytes into a frame, then sends
// SYNC, LEN and PKT_LEN payload slots paced by tx_done, followed by an idle gap.
module laser_tx_scheduler #(
    parameter int         PKT_LEN    = 8,
    parameter int         GAP_CYCLES = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  tx_data1,
    output logic [7:0]  tx_data2,
    output logic        tx_ready1,
    output logic        tx_ready2,
    input  logic        tx_done,
    output logic        tx_en,
    output logic        busy,
    output logic        err,
    output logic [15:0] frame_count
);
    localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [7:0]    FULL     = 8'(2 * PKT_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FILL, SYNC, LEN, SEND, GAP} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             count_q, count_d;
    logic [PKT_LEN*8-1:0]   lane1_q, lane1_d;
    logic [PKT_LEN*8-1:0]   lane2_q, lane2_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [7:0]             tx_data1_q, tx_data1_d;
    logic [7:0]             tx_data2_q, tx_data2_d;
    logic                   tx_strobe_q, tx_strobe_d;
    logic                   tx_en_q, tx_en_d;
    logic                   err_q, err_d;
    logic [15:0]            frame_count_q, frame_count_d;

    logic                   accept;
    logic [7:0]             cnt_next;
    logic [IW-1:0]          nidx;
    logic [7:0]             slot1, slot2;

    assign in_ready    = !reset && (state_q == IDLE || state_q == FILL) && (count_q < FULL);
    assign busy        = (state_q != IDLE);
    assign tx_data1    = tx_data1_q;
    assign tx_data2    = tx_data2_q;
    assign tx_ready1   = tx_strobe_q;
    assign tx_ready2   = tx_strobe_q;
    assign tx_en       = tx_en_q;
    assign err         = err_q;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        lane1_d       = lane1_q;
        lane2_d       = lane2_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        tx_data1_d    = tx_data1_q;
        tx_data2_d    = tx_data2_q;
        tx_strobe_d   = 1'b0;
        tx_en_d       = tx_en_q;
        err_d         = err_q;
        frame_count_d = frame_count_q;

        accept   = in_valid && in_ready;
        cnt_next = count_q + {7'd0, accept};
        // Payload slot to load next; slots beyond the held byte count go out as zero.
        nidx     = (state_q == SEND) ? idx_q + 1'b1 : '0;
        slot1    = (8'({nidx, 1'b0}) < count_q) ? lane1_q[int'(nidx)*8 +: 8] : 8'h00;
        slot2    = (8'({nidx, 1'b1}) < count_q) ? lane2_q[int'(nidx)*8 +: 8] : 8'h00;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (count_q[0]) lane2_d[int'(count_q[7:1])*8 +: 8] = in_data;
                    else            lane1_d[int'(count_q[7:1])*8 +: 8] = in_data;
                end
                count_d = cnt_next;
                if (cnt_next == FULL || (flush && cnt_next != 8'd0)) begin
                    state_d     = SYNC;
                    tx_strobe_d = 1'b1;
                    tx_data1_d  = SYNC_BYTE;
                    tx_data2_d  = SYNC_BYTE;
                    tx_en_d     = 1'b1;
                    timer_d     = '0;
                end else if (cnt_next != 8'd0) begin
                    state_d = FILL;
                end
            end
            SYNC, LEN, SEND: begin
                if (tx_done) begin
                    timer_d = '0;
                    if (state_q == SEND && idx_q == LAST_IDX) begin
                        state_d       = GAP;
                        gap_d         = '0;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        tx_strobe_d = 1'b1;
                        if (state_q == SYNC) begin
                            state_d    = LEN;
                            tx_data1_d = count_q;
                            tx_data2_d = count_q;
                        end else begin
                            state_d    = SEND;
                            idx_d      = nidx;
                            tx_data1_d = slot1;
                            tx_data2_d = slot2;
                        end
                    end
                end else if (timer_q == TO_LAST) begin
                    // Transmitter stalled: drop the whole frame and latch the error.
                    err_d      = 1'b1;
                    state_d    = IDLE;
                    count_d    = 8'd0;
                    tx_en_d    = 1'b0;
                    tx_data1_d = 8'h00;
                    tx_data2_d = 8'h00;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    count_d = 8'd0;
                    tx_en_d = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= 8'd0;
            lane1_q       <= '0;
            lane2_q       <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            tx_data1_q    <= 8'h00;
            tx_data2_q    <= 8'h00;
            tx_strobe_q   <= 1'b0;
            tx_en_q       <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            lane1_q       <= lane1_d;
            lane2_q       <= lane2_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            tx_data1_q    <= tx_data1_d;
            tx_data2_q    <= tx_data2_d;
            tx_strobe_q   <= tx_strobe_d;
            tx_en_q       <= tx_en_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end
endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Bench for laser_tx_scheduler: scenario tasks plus randomized frames checked
// against a frame-level model of the expected symbol pairs.
module tb_laser_tx_scheduler;
    localparam int         PKT  = 2;
    localparam int         GAP  = 4;
    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  tx_data1, tx_data2;
    logic        tx_ready1, tx_ready2;
    logic        tx_done = 1'b0;
    logic        tx_en, busy, err;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;
    int exp_fc = 0;
    int en_cyc = 0;
    int split_cnt = 0;
    int strobe_num = 0;
    int skip_strobe = -1;
    int rsp_delay = 3;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    laser_tx_scheduler #(.PKT_LEN(PKT), .GAP_CYCLES(GAP), .SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .tx_data1(tx_data1), .tx_data2(tx_data2),
        .tx_ready1(tx_ready1), .tx_ready2(tx_ready2), .tx_done(tx_done), .tx_en(tx_en),
        .busy(busy), .err(err), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    // Transmitter model: raises tx_done for one cycle rsp_delay cycles after each strobe.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            tx_done = 1'b0;
            if (reset) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
                if (tx_ready1 === 1'b1) begin
                    strobe_num++;
                    if (strobe_num != skip_strobe) cnt = rsp_delay;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (tx_ready1 === 1'b1 || tx_ready2 === 1'b1) got_q.push_back({tx_data1, tx_data2});
            if (tx_ready1 !== tx_ready2) split_cnt++;
            if (tx_en === 1'b1) en_cyc++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog sim did not finish");
        $fatal(1, "watchdog");
    end

    // Frame-level model: SYNC pair, LEN pair, then PKT payload pairs zero-padded.
    function automatic void build_exp(input logic [7:0] b[$]);
        int n;
        n = b.size();
        exp_q.push_back({SYNC, SYNC});
        exp_q.push_back({8'(n), 8'(n)});
        for (int i = 0; i < PKT; i++) begin
            logic [7:0] l1, l2;
            l1 = (2*i < n) ? b[2*i] : 8'h00;
            l2 = (2*i+1 < n) ? b[2*i+1] : 8'h00;
            exp_q.push_back({l1, l2});
        end
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic f, output int waits);
        waits = 0;
        forever begin
            @(negedge clock);
            in_data = b; in_valid = 1'b1; flush = f;
            if (in_ready === 1'b1) break;
            waits++;
            if (waits > 300) begin
                total++; bad++;
                $display("FAIL push_timeout byte=%h", b);
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clock); #1; t++;
        end while (busy !== 1'b0 && t < 500);
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL idle_timeout busy=%b", busy);
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if ({tx_ready1, tx_ready2, tx_en, busy, err} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b want=00000", {tx_ready1, tx_ready2, tx_en, busy, err}); end
        total++; if ({tx_data1, tx_data2} !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h want=0000", {tx_data1, tx_data2}); end
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL rst_fc got=%h want=0000", frame_count); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_full_frame();
        logic [7:0] b[$];
        int w;
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        rsp_delay = 3; got_q.delete(); exp_q.delete(); en_cyc = 0;
        foreach (b[i]) push_byte(b[i], 1'b0, w);
        idle_inputs();
        wait_idle();
        exp_fc++;
        build_exp(b);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_npairs got=%0d want=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_pair%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (en_cyc != (PKT+2)*(rsp_delay+1)+GAP) begin bad++; $display("FAIL full_tx_en_cycles got=%0d want=%0d", en_cyc, (PKT+2)*(rsp_delay+1)+GAP); end
        total++; if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL full_fc got=%0d want=%0d", frame_count, exp_fc); end
    endtask

    task automatic test_flush();
        logic [7:0] b[$];
        int w;
        // Flush with nothing held must not start a frame.
        got_q.delete();
        pulse_flush();
        repeat (5) @(negedge clock);
        total++; if (busy !== 1'b0 || got_q.size() != 0) begin bad++; $display("FAIL flush_empty busy=%b strobes=%0d want 0/0", busy, got_q.size()); end

        b = '{8'h55};
        rsp_delay = 2; exp_q.delete(); en_cyc = 0;
        push_byte(b[0], 1'b0, w);
        pulse_flush();
        wait_idle();
        exp_fc++;
        build_exp(b);
        b = '{8'h77};
        push_byte(b[0], 1'b1, w);
        idle_inputs();
        wait_idle();
        exp_fc++;
        build_exp(b);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL flush_npairs got=%0d want=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL flush_pair%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (en_cyc != 2*((PKT+2)*(rsp_delay+1)+GAP)) begin bad++; $display("FAIL flush_tx_en_cycles got=%0d want=%0d", en_cyc, 2*((PKT+2)*(rsp_delay+1)+GAP)); end
        total++; if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL flush_fc got=%0d want=%0d", frame_count, exp_fc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1[$], f2[$];
        int w;
        f1 = '{8'h01, 8'h02, 8'h03, 8'h04};
        f2 = '{8'h05, 8'h06};
        rsp_delay = 1; got_q.delete(); exp_q.delete();
        foreach (f1[i]) push_byte(f1[i], 1'b0, w);
        push_byte(f2[0], 1'b0, w);
        total++; if (w == 0 || busy !== 1'b0) begin bad++; $display("FAIL bp_byte5 waits=%0d busy=%b want waits>0 busy=0", w, busy); end
        push_byte(f2[1], 1'b0, w);
        total++; if (w != 0) begin bad++; $display("FAIL bp_byte6 waits=%0d want 0", w); end
        pulse_flush();
        wait_idle();
        exp_fc += 2;
        build_exp(f1);
        build_exp(f2);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_npairs got=%0d want=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_pair%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL bp_fc got=%0d want=%0d", frame_count, exp_fc); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            logic [7:0] b[$];
            int n, mode, w;
            n = $urandom_range(1, 2*PKT);
            mode = $urandom_range(0, 1);
            rsp_delay = $urandom_range(1, 5);
            got_q.delete(); exp_q.delete(); en_cyc = 0;
            for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) idle_inputs();
                push_byte(b[k], (k == n-1 && n < 2*PKT && mode == 1), w);
            end
            idle_inputs();
            if (n < 2*PKT && mode == 0) pulse_flush();
            wait_idle();
            exp_fc++;
            build_exp(b);
            total++;
            if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_npairs got=%0d want=%0d", f, got_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_pair%0d got=%h want=%h", f, i, got_q[i], exp_q[i]); end
            end
            total++; if (en_cyc != (PKT+2)*(rsp_delay+1)+GAP) begin bad++; $display("FAIL rnd%0d_tx_en_cycles got=%0d want=%0d", f, en_cyc, (PKT+2)*(rsp_delay+1)+GAP); end
            total++; if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL rnd%0d_fc got=%0d want=%0d", f, frame_count, exp_fc); end
        end
        total++; if (split_cnt != 0) begin bad++; $display("FAIL strobe_split got=%0d want=0", split_cnt); end
    endtask

    task automatic test_timeout();
        logic [7:0] b[$];
        int w, t;
        rsp_delay = 3; got_q.delete(); exp_q.delete();
        skip_strobe = strobe_num + 2;
        for (int k = 0; k < 2*PKT; k++) push_byte(8'($urandom_range(0, 255)), 1'b0, w);
        idle_inputs();
        t = 0;
        do begin @(negedge clock); #1; t++; end while (got_q.size() < 2 && t < 200);
        if (got_q.size() < 2) begin total++; bad++; $display("FAIL to_len_strobe_timeout strobes=%0d", got_q.size()); end
        repeat (TO-1) @(negedge clock);
        total++; if (err !== 1'b0 || tx_en !== 1'b1) begin bad++; $display("FAIL to_early err=%b tx_en=%b want 0/1", err, tx_en); end
        @(negedge clock);
        total++; if (err !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_fire err=%b tx_en=%b busy=%b want 1/0/0", err, tx_en, busy); end
        total++; if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL to_fc got=%0d want=%0d", frame_count, exp_fc); end
        skip_strobe = -1;
        got_q.delete();
        b = '{8'h9C, 8'h3E, 8'hD1};
        foreach (b[i]) push_byte(b[i], (i == 2), w);
        idle_inputs();
        wait_idle();
        exp_fc++;
        build_exp(b);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL to_next_npairs got=%0d want=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL to_next_pair%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (err !== 1'b1 || frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL to_next err=%b fc=%0d want 1/%0d", err, frame_count, exp_fc); end
    endtask

    task automatic test_reset_mid();
        int w, t, n;
        rsp_delay = 3; got_q.delete();
        for (int k = 0; k < 2*PKT; k++) push_byte(8'($urandom_range(1, 255)), 1'b0, w);
        idle_inputs();
        t = 0;
        do begin @(negedge clock); #1; t++; end while (got_q.size() < 3 && t < 200);
        if (got_q.size() < 3) begin total++; bad++; $display("FAIL rm_send_timeout strobes=%0d", got_q.size()); end
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        total++; if ({tx_ready1, tx_ready2, tx_en, busy, err, in_ready} !== 6'b0) begin bad++; $display("FAIL rm_flags got=%b want=000000", {tx_ready1, tx_ready2, tx_en, busy, err, in_ready}); end
        total++; if ({tx_data1, tx_data2, frame_count} !== 32'h0) begin bad++; $display("FAIL rm_data got=%h want=0", {tx_data1, tx_data2, frame_count}); end
        exp_fc = 0;
        n = got_q.size();
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b want=1", in_ready); end
        pulse_flush();
        repeat (8) @(negedge clock);
        total++; if (got_q.size() != n || busy !== 1'b0) begin bad++; $display("FAIL rm_empty_flush strobes=%0d busy=%b want %0d/0", got_q.size(), busy, n); end
    endtask

    task automatic test_wrap();
        int w;
        @(negedge clock);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.frame_count_q;
        #1;
        total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h want=ffff", frame_count); end
        rsp_delay = 2;
        push_byte(8'h42, 1'b1, w);
        idle_inputs();
        wait_idle();
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_fc got=%h want=0000", frame_count); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
